// File: rtl/sel_arbiter_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sel_pkg
// Description : Shared types and constants for the word-select arbiter /
//               encoder. Eight memory words, so addresses are 3 bits wide.
// Contents    : N_WORDS, ADR_W, arb_state_t, word_adr_t, adr2onehot()
// Revision    : 1.0 - initial release
// ============================================================================
package sel_pkg;

  localparam int N_WORDS = 8;
  localparam int ADR_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [ADR_W-1:0] word_adr_t;

  // One-hot word grant for an encoded address.
  function automatic logic [N_WORDS-1:0] adr2onehot(input word_adr_t a);
    return N_WORDS'(1) << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sel_arbiter_enc_if.sv
`default_nettype none
// ============================================================================
// Module      : sel_arbiter_enc_if
// Description : Request / grant bundle between the requesters and memory
//               control on one side and the arbiter on the other.
// Signals     : i_req[7:0]  per-word access request (level)
//               i_ack       access complete pulse from memory control
//               o_adr[2:0]  encoded granted word address
//               o_valid     address valid (feeds decoder valid)
//               o_gnt[7:0]  one-hot grant
//               o_timeout   1-cycle pulse on forced release
// Modports    : slave  - arbiter side
//               master - requester / memory-control side
// Revision    : 1.0 - initial release
// ============================================================================
interface sel_arbiter_enc_if;
  import sel_pkg::*;

  logic [N_WORDS-1:0] i_req;
  logic               i_ack;
  word_adr_t          o_adr;
  logic               o_valid;
  logic [N_WORDS-1:0] o_gnt;
  logic               o_timeout;

  modport slave (
    input  i_req,
    input  i_ack,
    output o_adr,
    output o_valid,
    output o_gnt,
    output o_timeout
  );

  modport master (
    output i_req,
    output i_ack,
    input  o_adr,
    input  o_valid,
    input  o_gnt,
    input  o_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sel_arbiter_enc_rr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_enc
// Description : Combinational round-robin priority encoder. Searches the
//               request vector starting at i_ptr and wrapping 7->0, returning
//               the first set index.
// Ports       : i_req[7:0]  request vector
//               i_ptr[2:0]  search start index
//               o_idx[2:0]  first requesting index at or after i_ptr
//               o_any       at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_enc
  import sel_pkg::*;
(
  input  wire logic [N_WORDS-1:0] i_req,
  input  wire word_adr_t          i_ptr,
  output word_adr_t               o_idx,
  output logic                    o_any
);

  // w_rot[k] is the request of word (i_ptr + k) mod 8; the 3-bit add wraps.
  logic [N_WORDS-1:0] w_rot;
  word_adr_t          w_ofs;

  for (genvar g = 0; g < N_WORDS; g++) begin : g_rot
    localparam word_adr_t c_OFS = word_adr_t'(g);
    word_adr_t w_src;
    assign w_src    = i_ptr + c_OFS;
    assign w_rot[g] = i_req[w_src];
  end

  // Lowest set offset in the rotated vector; scanning downwards lets the
  // last (lowest) hit win.
  always_comb begin
    w_ofs = '0;
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_ofs = word_adr_t'(i);
      end
    end
  end

  assign o_idx = i_ptr + w_ofs;
  assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/sel_arbiter_enc.sv
`default_nettype none
// ============================================================================
// Module      : sel_arbiter_enc
// Description : Round-robin arbiter and 8-to-3 encoder feeding the word
//               select decoder. Grants one word at a time, holds the grant
//               until i_ack or until TIMEOUT busy cycles expire, and always
//               leaves one idle cycle between grants.
// Parameters  : TIMEOUT - max busy cycles without i_ack (0 = no timeout)
// Ports       : i_clk    clock, rising edge
//               i_rst_n  synchronous active-low reset
//               bus      sel_arbiter_enc_if.slave (req/ack in, adr/valid/
//                        gnt/timeout out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sel_arbiter_enc
  import sel_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  sel_arbiter_enc_if.slave  bus
);

  // Timer is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int              TMR_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] c_TMR_MAX  = '1;
  localparam bit               c_TO_EN    = (TIMEOUT != 0);

  arb_state_t         r_state;
  word_adr_t          r_ptr;
  logic [TMR_W-1:0]   r_timer;
  word_adr_t          r_adr;
  logic               r_valid;
  logic [N_WORDS-1:0] r_gnt;
  logic               r_timeout;

  arb_state_t         w_state_nxt;
  word_adr_t          w_ptr_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  word_adr_t          w_adr_nxt;
  logic               w_valid_nxt;
  logic [N_WORDS-1:0] w_gnt_nxt;
  logic               w_timeout_nxt;

  word_adr_t          w_idx;
  logic               w_any;

  rr_prio_enc u_enc (
    .i_req (bus.i_req),
    .i_ptr (r_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // --------------------------------------------------------------------------
  // Next-state / next-output logic. Everything holds by default; o_timeout
  // defaults low so it can only ever pulse for the release cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_timer_nxt   = r_timer;
    w_adr_nxt     = r_adr;
    w_valid_nxt   = r_valid;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_adr_nxt   = w_idx;
          w_valid_nxt = 1'b1;
          w_gnt_nxt   = adr2onehot(w_idx);
          w_timer_nxt = '0;
        end
      end

      BUSY: begin
        // Requests are ignored here: the grant is held until released.
        if (bus.i_ack || (c_TO_EN && (r_timer == c_TMR_LAST))) begin
          w_state_nxt   = IDLE;
          w_valid_nxt   = 1'b0;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = r_adr + word_adr_t'(1);
          // Ack takes priority, so a coincident ack suppresses the pulse.
          w_timeout_nxt = ~bus.i_ack;
        end else if (r_timer != c_TMR_MAX) begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_adr     <= '0;
      r_valid   <= 1'b0;
      r_gnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_adr     <= w_adr_nxt;
      r_valid   <= w_valid_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.o_adr     = r_adr;
  assign bus.o_valid   = r_valid;
  assign bus.o_gnt     = r_gnt;
  assign bus.o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sel_arbiter_enc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_arbiter_enc
// Description : Self-checking bench for sel_arbiter_enc (TIMEOUT=4). Directed
//               steps followed by random traffic, each cycle compared against
//               a behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_arbiter_enc;

  localparam int TO = 4;

  logic clk;
  logic rst_n;

  sel_arbiter_enc_if bus ();

  sel_arbiter_enc #(.TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: busy flag, granted word, search start, busy-cycle count.
  bit m_busy = 0;
  int m_adr  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_to   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] req, input bit ack, input bit rn);
    m_to = 0;
    if (!rn) begin
      m_busy = 0; m_adr = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_adr = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
      if (ack) begin
        m_busy = 0;
        m_ptr  = (m_adr + 1) % 8;
      end else if (TO != 0 && m_cnt == TO) begin
        m_busy = 0;
        m_ptr  = (m_adr + 1) % 8;
        m_to   = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic [7:0] req, input bit ack, input bit rn);
    logic [7:0] e_gnt;
    bus.i_req = req;
    bus.i_ack = ack;
    rst_n     = rn;
    @(posedge clk);
    model_edge(req, ack, rn);
    #1;
    e_gnt = m_busy ? (8'd1 << m_adr) : 8'd0;
    chk("m_adr",     {5'd0, bus.o_adr},     8'(m_adr));
    chk("m_valid",   {7'd0, bus.o_valid},   {7'd0, m_busy});
    chk("m_gnt",     bus.o_gnt,             e_gnt);
    chk("m_timeout", {7'd0, bus.o_timeout}, {7'd0, m_to});
  endtask

  initial begin
    bus.i_req = '0;
    bus.i_ack = 1'b0;
    rst_n     = 1'b0;

    // 1. Reset with all requests active, then first grant is word 0.
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 0, 0);
      chk("rst_valid", {7'd0, bus.o_valid}, 8'd0);
      chk("rst_gnt", bus.o_gnt, 8'd0);
    end
    step(8'hFF, 0, 1);
    chk("rst_first_adr", {5'd0, bus.o_adr}, 8'd0);
    step(8'h00, 1, 1);

    // 2. Single request, drop while busy, then ack.
    step(8'h20, 0, 1);
    chk("single_adr", {5'd0, bus.o_adr}, 8'd5);
    chk("single_gnt", bus.o_gnt, 8'h20);
    step(8'h00, 0, 1);
    step(8'h00, 0, 1);
    chk("single_hold", bus.o_gnt, 8'h20);
    step(8'h00, 1, 1);
    chk("single_rel", {7'd0, bus.o_valid}, 8'd0);

    // 4. Wrap scan from ptr=6: 0 first, then 3.
    step(8'h09, 0, 1);
    chk("wrap_first", {5'd0, bus.o_adr}, 8'd0);
    step(8'h09, 1, 1);
    step(8'h09, 0, 1);
    chk("wrap_second", {5'd0, bus.o_adr}, 8'd3);
    step(8'h00, 1, 1);

    // 3. Round robin from ptr=0 with constant requests.
    step(8'h00, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 0, 1);
      chk("rr_adr", {5'd0, bus.o_adr}, 8'(i % 8));
      step(8'hFF, 1, 1);
      chk("rr_gap", {7'd0, bus.o_valid}, 8'd0);
    end

    // 5. Timeout on word 2, then scan resumes from 3.
    step(8'h00, 0, 0);
    step(8'h04, 0, 1);
    chk("to_grant", {5'd0, bus.o_adr}, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 0, 1);
      chk("to_busy", {7'd0, bus.o_valid}, 8'd1);
    end
    step(8'h00, 0, 1);
    chk("to_release", {7'd0, bus.o_valid}, 8'd0);
    chk("to_pulse", {7'd0, bus.o_timeout}, 8'd1);
    step(8'hFF, 0, 1);
    chk("to_pulse_end", {7'd0, bus.o_timeout}, 8'd0);
    chk("to_next", {5'd0, bus.o_adr}, 8'd3);
    step(8'h00, 1, 1);
    // Ack in the fourth busy cycle beats the timeout.
    step(8'h04, 0, 1);
    for (int i = 0; i < 3; i++) step(8'h00, 0, 1);
    step(8'h00, 1, 1);
    chk("to_ack_rel", {7'd0, bus.o_valid}, 8'd0);
    chk("to_ack_nopulse", {7'd0, bus.o_timeout}, 8'd0);

    // 6. Reset while busy on word 6.
    step(8'h40, 0, 1);
    chk("rb_grant", {5'd0, bus.o_adr}, 8'd6);
    step(8'h40, 0, 0);
    chk("rb_gnt", bus.o_gnt, 8'd0);
    step(8'h41, 0, 1);
    chk("rb_after", {5'd0, bus.o_adr}, 8'd0);
    step(8'h00, 1, 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      step(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
